// File: rtl/md_sequencer.sv
// Execute-stage sequencer for the iterative multiply/divide unit: it launches the
// unit, stalls the front of the pipe, and presents the result for X/M capture.
module md_sequencer #(
    parameter int          MAX_CYCLES  = 40,
    parameter logic [31:0] MUL_ERR     = 32'd4,
    parameter logic [31:0] DIV_ERR     = 32'd5,
    parameter logic [31:0] TIMEOUT_ERR = 32'd6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir_x,
    input  logic        flush,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        md_done,
    output logic [31:0] o_out,
    output logic        isRStatus_out,
    output logic [31:0] rStatus_out,
    output logic [5:0]  busy_cycles,
    output logic [1:0]  state_dbg
);

    // Handshake: ctrl_MULT/ctrl_DIV are single-cycle launch strobes; the unit answers
    // with a single-cycle md_resultRDY carrying md_result/md_exception. md_done is a
    // single-cycle strobe in which o_out/isRStatus_out/rStatus_out are valid for X/M.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   op_mul, op_mul_nxt;

    logic is_mul, is_div, is_md;
    logic timeout_hit;
    logic capture;

    logic [31:0] res_nxt;
    logic        isr_nxt;
    logic [31:0] rs_nxt;

    assign is_mul = (ir_x[31:27] == 5'b00000) && (ir_x[6:2] == 5'b00110);
    assign is_div = (ir_x[31:27] == 5'b00000) && (ir_x[6:2] == 5'b00111);
    assign is_md  = is_mul | is_div;

    assign timeout_hit = (busy_cycles == 6'(MAX_CYCLES - 1));
    assign state_dbg   = state;

    always_comb begin
        state_nxt  = state;
        op_mul_nxt = op_mul;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = is_md & ~flush;
                if (is_md && !flush) begin
                    state_nxt  = START;
                    op_mul_nxt = is_mul;
                end
            end
            START: begin
                stall     = ~flush;
                state_nxt = flush ? IDLE : BUSY;
            end
            BUSY: begin
                stall = ~flush;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (md_resultRDY || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Result is already committed; a late flush cannot retract it.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A real response wins over a timeout landing in the same cycle.
    always_comb begin
        res_nxt = md_result;
        isr_nxt = md_exception;
        rs_nxt  = md_exception ? (op_mul ? MUL_ERR : DIV_ERR) : 32'd0;
        if (!md_resultRDY) begin
            res_nxt = 32'd0;
            isr_nxt = 1'b1;
            rs_nxt  = TIMEOUT_ERR;
        end
    end

    assign capture = (state == BUSY) && (state_nxt == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_mul        <= 1'b0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            md_done       <= 1'b0;
            busy_cycles   <= 6'd0;
            o_out         <= 32'd0;
            isRStatus_out <= 1'b0;
            rStatus_out   <= 32'd0;
        end else begin
            state     <= state_nxt;
            op_mul    <= op_mul_nxt;
            ctrl_MULT <= (state_nxt == START) && op_mul_nxt;
            ctrl_DIV  <= (state_nxt == START) && !op_mul_nxt;
            md_done   <= (state_nxt == DONE);

            // Counter holds on the exit edge so it reports the index of the last BUSY cycle.
            if (state == START) begin
                busy_cycles <= 6'd0;
            end else if (state == BUSY && state_nxt == BUSY && busy_cycles != 6'd63) begin
                busy_cycles <= busy_cycles + 6'd1;
            end

            if (capture) begin
                o_out         <= res_nxt;
                isRStatus_out <= isr_nxt;
                rStatus_out   <= rs_nxt;
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized scoreboard bench for md_sequencer against a transaction-level model.
module tb_md_sequencer;
  localparam int MAX = 40;
  localparam int W   = 71;  // {o_out[32], isRStatus[1], rStatus[32], busy_cycles[6]}

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_x;
  logic        flush;
  logic        md_resultRDY;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_done;
  logic [31:0] o_out;
  logic        isRStatus_out;
  logic [31:0] rStatus_out;
  logic [5:0]  busy_cycles;
  logic [1:0]  state_dbg;

  md_sequencer #(.MAX_CYCLES(MAX)) dut (
    .clock(clock), .reset(reset), .ir_x(ir_x), .flush(flush),
    .md_resultRDY(md_resultRDY), .md_exception(md_exception), .md_result(md_result),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .md_done(md_done),
    .o_out(o_out), .isRStatus_out(isRStatus_out), .rStatus_out(rStatus_out),
    .busy_cycles(busy_cycles), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mul_pulses = 0, div_pulses = 0;
  int exp_mul = 0, exp_div = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] md_instr(input bit is_mul);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'b00000;
    r[6:2] = is_mul ? 5'b00110 : 5'b00111;
    return r;
  endfunction

  function automatic logic [31:0] plain_instr();
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'b00101;
    return r;
  endfunction

  // Reference: the op ends on the response cycle if it arrives within MAX BUSY cycles,
  // otherwise at the MAX-th BUSY cycle with a timeout status.
  function automatic int end_cycle(input int lat);
    return (lat >= 1 && lat <= MAX) ? lat : MAX;
  endfunction

  function automatic logic [W-1:0] model(input bit is_mul, input int lat, input bit exc,
                                         input logic [31:0] res);
    logic [31:0] code;
    if (lat >= 1 && lat <= MAX) begin
      code = exc ? (is_mul ? 32'd4 : 32'd5) : 32'd0;
      return {res, exc, code, 6'(lat - 1)};
    end
    return {32'd0, 1'b1, 32'd6, 6'(MAX - 1)};
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (ctrl_MULT) mul_pulses++;
      if (ctrl_DIV) div_pulses++;
      if (md_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_md_done", 64'(md_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("o_out", 64'(o_out), 64'(e[70:39]));
          check("isRStatus_out", 64'(isRStatus_out), 64'(e[38]));
          check("rStatus_out", 64'(rStatus_out), 64'(e[37:6]));
          check("busy_cycles", 64'(busy_cycles), 64'(e[5:0]));
          last_exp = e;
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      ir_x = plain_instr(); flush = 1'b0; md_resultRDY = 1'b0;
      @(negedge clock);
      check("plain_no_stall", 64'(stall), 64'd0);
    end
  endtask

  // flush_at: 0 none, -1 flush while the op sits in IDLE, k>0 flush in BUSY cycle k
  task automatic run_op(input bit is_mul, input int lat, input bit exc,
                        input logic [31:0] res, input int flush_at);
    int stalls;
    bit done;
    @(posedge clock); #1;
    ir_x = md_instr(is_mul); flush = (flush_at < 0); md_resultRDY = 1'b0;
    @(negedge clock);
    check("idle_stall", 64'(stall), (flush_at < 0) ? 64'd0 : 64'd1);
    if (flush_at < 0) begin
      @(posedge clock); #1;
      flush = 1'b0; ir_x = plain_instr();
      repeat (3) begin
        @(negedge clock);
        check("no_launch", 64'({ctrl_MULT, ctrl_DIV, stall}), 64'd0);
      end
      return;
    end
    if (flush_at == 0) exp_q.push_back(model(is_mul, lat, exc, res));
    if (is_mul) exp_mul++; else exp_div++;
    stalls = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check("start_pulse", 64'({ctrl_MULT, ctrl_DIV}), is_mul ? 64'd2 : 64'd1);
    if (stall) stalls++;
    done = 1'b0;
    for (int j = 1; j <= MAX + 8 && !done; j++) begin
      @(posedge clock); #1;
      md_resultRDY = (j == lat);
      md_result = (j == lat) ? res : $urandom;
      md_exception = (j == lat) ? exc : 1'($urandom_range(0, 1));
      flush = (j == flush_at);
      @(negedge clock);
      if (flush) begin
        check("flush_stall_drop", 64'(stall), 64'd0);
        @(posedge clock); #1;
        flush = 1'b0; md_resultRDY = 1'b0; ir_x = plain_instr();
        repeat (3) begin
          @(negedge clock);
          check("flush_hold_o", 64'(o_out), 64'(last_exp[70:39]));
          check("flush_hold_status", 64'({isRStatus_out, rStatus_out}),
                64'({last_exp[38], last_exp[37:6]}));
          check("flush_no_stall", 64'(stall), 64'd0);
        end
        return;
      end
      if (md_done) begin
        done = 1'b1;
        check("done_stall", 64'(stall), 64'd0);
      end else if (stall) begin
        stalls++;
      end
    end
    check("md_done_seen", 64'(done), 64'd1);
    check("stall_cycles", 64'(stalls), 64'(end_cycle(lat) + 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ir_x = 32'd0; flush = 1'b0;
    md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    #12;
    check("reset_outputs", 64'({ctrl_MULT, ctrl_DIV, md_done, stall, isRStatus_out, busy_cycles}), 64'd0);
    check("reset_o_rs", 64'({o_out, rStatus_out}), 64'd0);
    @(negedge clock); reset = 1'b0;
    idle(2);

    // directed cases
    run_op(1'b1, 4, 1'b0, 32'd42, 0);        idle(2);
    run_op(1'b0, 3, 1'b1, 32'h1234, 0);      idle(1);
    run_op(1'b1, 0, 1'b0, 32'd0, 0);         idle(1);   // no response: timeout
    run_op(1'b1, 10, 1'b0, 32'hdead, 3);     idle(1);   // flushed in BUSY cycle 3
    run_op(1'b0, 5, 1'b0, 32'h55, -1);       idle(1);   // flushed before launch
    run_op(1'b1, 5, 1'b0, 32'd7, 0);
    run_op(1'b1, MAX, 1'b0, 32'd9, 0);                  // response on the timeout cycle
    idle(2);

    // reset in the middle of BUSY
    @(posedge clock); #1;
    ir_x = md_instr(1'b1);
    exp_mul++;
    repeat (6) @(posedge clock);
    #2;
    ir_x = plain_instr(); reset = 1'b1;
    #1;
    check("midbusy_reset_ctrl", 64'({ctrl_MULT, ctrl_DIV, md_done, stall, busy_cycles}), 64'd0);
    check("midbusy_reset_data", 64'({o_out, isRStatus_out, rStatus_out}), 64'd0);
    last_exp = '0;
    @(negedge clock); reset = 1'b0;
    idle(2);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      bit m, x;
      int lat, fa, e;
      m = 1'($urandom_range(0, 1));
      x = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, MAX + 5);
      e = end_cycle(lat);
      fa = 0;
      if ($urandom_range(0, 5) == 0 && e >= 2) fa = $urandom_range(1, e - 1);
      else if ($urandom_range(0, 7) == 0) fa = -1;
      run_op(m, lat, x, $urandom, fa);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("mul_pulse_count", 64'(mul_pulses), 64'(exp_mul));
    check("div_pulse_count", 64'(div_pulses), 64'(exp_div));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
